sensor_conditioner: RTL and testbench

Upstream front-end of the irrigation controller. It samples the raw field sensors (water levels H/M/L, air humidity Ua, soil humidity Us, temperature T) and the display-select push-button. Each input is synchronised and debounced. The button becomes a toggled display select S. The outputs are clean, registered levels that drive the combinational irrigation/display logic directly.

---
 rtl/irrig_pkg.sv | 24 ++
 rtl/debounce_cell.sv | 64 ++++++
 rtl/sensor_conditioner.sv | 116 +++++++++++
 tb/tb_sensor_conditioner.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irrig_pkg.sv
`default_nettype none
// ============================================================================
//  irrig_pkg
//  Shared constants and sensor-vector index map for the irrigation controller.
//  Revision: 1.0
// ============================================================================
package irrig_pkg;

    localparam int TICK_DIV_DEF = 50000;
    localparam int DB_TICKS_DEF = 20;
    localparam int N_SENS       = 7;

    typedef enum logic [2:0] {
        IDX_H  = 3'd0,
        IDX_M  = 3'd1,
        IDX_L  = 3'd2,
        IDX_UA = 3'd3,
        IDX_US = 3'd4,
        IDX_T  = 3'd5,
        IDX_S  = 3'd6
    } sens_idx_e;

endpackage
`default_nettype wire

// File: rtl/debounce_cell.sv
`default_nettype none
// ============================================================================
//  debounce_cell
//  2-FF synchroniser plus tick-sampled debouncer for one raw input.
//  Revision: 1.0
// ============================================================================
module debounce_cell
    import irrig_pkg::*;
#(
    parameter int DB_TICKS = DB_TICKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic din,
    output logic dout
);

    localparam int            CW       = $clog2(DB_TICKS) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          out_q;
    logic          out_d;

    // The count never passes CNT_LAST: it either flips the output or clears.
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (tick) begin
            if (sync2_q != out_q) begin
                if (cnt_q >= CNT_LAST) begin
                    out_d = ~out_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign dout = out_q;

endmodule
`default_nettype wire

// File: rtl/sensor_conditioner.sv
`default_nettype none
// ============================================================================
//  sensor_conditioner
//  Synchronises and debounces the field sensors, toggles the display select.
//  Revision: 1.0
// ============================================================================
module sensor_conditioner
    import irrig_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int DB_TICKS = DB_TICKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic H_raw,
    input  logic M_raw,
    input  logic L_raw,
    input  logic Ua_raw,
    input  logic Us_raw,
    input  logic T_raw,
    input  logic S_btn,
    output logic H,
    output logic M,
    output logic L,
    output logic Ua,
    output logic Us,
    output logic T,
    output logic S,
    output logic ready,
    output logic tick
);

    localparam int            PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam int            RW       = $clog2(DB_TICKS) + 1;
    localparam logic [RW-1:0] RDY_LAST = RW'(DB_TICKS - 1);

    logic [PW-1:0]     pre_q;
    logic [PW-1:0]     pre_d;
    logic              tick_q;
    logic [RW-1:0]     rdy_cnt_q;
    logic              ready_q;
    logic              btn_prev_q;
    logic              sel_q;
    logic [N_SENS-1:0] raw_vec;
    logic [N_SENS-1:0] db_vec;

    always_comb begin
        raw_vec         = '0;
        raw_vec[IDX_H]  = H_raw;
        raw_vec[IDX_M]  = M_raw;
        raw_vec[IDX_L]  = L_raw;
        raw_vec[IDX_UA] = Ua_raw;
        raw_vec[IDX_US] = Us_raw;
        raw_vec[IDX_T]  = T_raw;
        raw_vec[IDX_S]  = S_btn;
    end

    assign pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;

    // tick is registered from the next count so it is high exactly while pre_q sits at PRE_LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= (pre_d == PRE_LAST);
        end
    end

    generate
        for (genvar g = 0; g < N_SENS; g++) begin : g_cells
            debounce_cell #(
                .DB_TICKS (DB_TICKS)
            ) u_cell (
                .clk  (clk),
                .rst  (rst),
                .tick (tick_q),
                .din  (raw_vec[g]),
                .dout (db_vec[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev_q <= 1'b0;
            sel_q      <= 1'b0;
            rdy_cnt_q  <= '0;
            ready_q    <= 1'b0;
        end else begin
            btn_prev_q <= db_vec[IDX_S];
            sel_q      <= sel_q ^ (db_vec[IDX_S] & ~btn_prev_q);
            if (tick_q) begin
                if (rdy_cnt_q == RDY_LAST) begin
                    ready_q <= 1'b1;
                end else begin
                    rdy_cnt_q <= rdy_cnt_q + 1'b1;
                end
            end
        end
    end

    assign H     = db_vec[IDX_H];
    assign M     = db_vec[IDX_M];
    assign L     = db_vec[IDX_L];
    assign Ua    = db_vec[IDX_UA];
    assign Us    = db_vec[IDX_US];
    assign T     = db_vec[IDX_T];
    assign S     = sel_q;
    assign ready = ready_q;
    assign tick  = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
`default_nettype none
// ============================================================================
//  tb_sensor_conditioner
//  Self-checking bench: directed table, corner sequences, random vs model.
//  Revision: 1.0
// ============================================================================
module tb_sensor_conditioner;

    localparam int TD = 4;
    localparam int DB = 3;

    logic clk = 1'b0;
    logic rst;
    logic H_raw, M_raw, L_raw, Ua_raw, Us_raw, T_raw, S_btn;
    logic H, M, L, Ua, Us, T, S, ready, tick;
    logic [6:0] cur_raw;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sensor_conditioner #(
        .TICK_DIV (TD),
        .DB_TICKS (DB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .H_raw  (H_raw),
        .M_raw  (M_raw),
        .L_raw  (L_raw),
        .Ua_raw (Ua_raw),
        .Us_raw (Us_raw),
        .T_raw  (T_raw),
        .S_btn  (S_btn),
        .H      (H),
        .M      (M),
        .L      (L),
        .Ua     (Ua),
        .Us     (Us),
        .T      (T),
        .S      (S),
        .ready  (ready),
        .tick   (tick)
    );

    // Reference model: counts of consecutive disagreeing ticks per input.
    int         m_pc;
    int         m_ticks;
    int         m_run [7];
    logic [6:0] m_s1, m_s2, m_out;
    logic       m_prev, m_sel, m_ready;

    typedef struct {
        logic [6:0] raw;
        logic [6:0] exp;
        logic       rdy;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic set_raw(input logic [6:0] v);
        cur_raw = v;
        H_raw   = v[0];
        M_raw   = v[1];
        L_raw   = v[2];
        Ua_raw  = v[3];
        Us_raw  = v[4];
        T_raw   = v[5];
        S_btn   = v[6];
    endtask

    task automatic model_reset();
        m_pc    = 0;
        m_ticks = 0;
        for (int i = 0; i < 7; i++) m_run[i] = 0;
        m_s1    = '0;
        m_s2    = '0;
        m_out   = '0;
        m_prev  = 1'b0;
        m_sel   = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic model_step(input logic [6:0] r);
        logic tk;
        tk = (m_pc == TD - 1);
        if (m_out[6] && !m_prev) m_sel = !m_sel;
        m_prev = m_out[6];
        if (tk) begin
            for (int i = 0; i < 7; i++) begin
                if (m_s2[i] !== m_out[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_out[i] = ~m_out[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            if (m_ticks < DB) m_ticks++;
            m_ready = (m_ticks >= DB);
        end
        m_s2 = m_s1;
        m_s1 = r;
        m_pc = (m_pc + 1) % TD;
    endtask

    function automatic logic [8:0] dut_all();
        return {tick, ready, S, T, Us, Ua, L, M, H};
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(cur_raw);
        #1;
        check("model", {23'd0, dut_all()},
              {23'd0, (m_pc == TD - 1), m_ready, m_sel, m_out[5:0]});
    endtask

    initial begin
        int  lat;
        bit  found;
        bit  flag;
        logic [6:0] v;

        tbl[0] = '{7'b0000000, 7'b0000000, 1'b1};
        tbl[1] = '{7'b0000001, 7'b0000001, 1'b1};
        tbl[2] = '{7'b0010101, 7'b0010101, 1'b1};
        tbl[3] = '{7'b1101010, 7'b1101010, 1'b1};
        tbl[4] = '{7'b0111111, 7'b1111111, 1'b1};
        tbl[5] = '{7'b1000000, 7'b0000000, 1'b1};
        tbl[6] = '{7'b0000000, 7'b0000000, 1'b1};
        tbl[7] = '{7'b0111111, 7'b0111111, 1'b1};

        rst = 1'b1;
        set_raw(7'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {23'd0, dut_all()}, 32'd0);
        rst = 1'b0;

        // Startup: tick phase and ready settle
        for (int e = 1; e <= 16; e++) begin
            step();
            check("tick_phase", {31'd0, tick}, {31'd0, (e % 4 == 3)});
            if (e == 11) check("ready_before_3rd_tick", {31'd0, ready}, 32'd0);
            if (e == 12) check("ready_at_3rd_tick", {31'd0, ready}, 32'd1);
        end
        check("startup_sensors_low", {26'd0, T, Us, Ua, L, M, H}, 32'd0);

        // Directed table
        for (int k = 0; k < 8; k++) begin
            set_raw(tbl[k].raw);
            repeat (20) step();
            check("table", {24'd0, ready, S, T, Us, Ua, L, M, H},
                  {24'd0, tbl[k].rdy, tbl[k].exp});
        end

        // Glitch on M spanning at most two ticks
        set_raw(7'd0);
        repeat (20) step();
        set_raw(7'b0000010);
        repeat (6) step();
        set_raw(7'd0);
        flag = 1'b0;
        repeat (30) begin
            step();
            if (M) flag = 1'b1;
        end
        check("glitch_M_ignored", {31'd0, flag}, 32'd0);

        // Clean edge latency bounds
        set_raw(7'b0000010);
        found = 1'b0;
        lat   = 0;
        for (int k = 1; k <= 40 && !found; k++) begin
            step();
            if (M) begin
                found = 1'b1;
                lat   = k;
            end
        end
        check("M_latency_11_to_14", {31'd0, (found && lat >= 11 && lat <= 14)}, 32'd1);

        // Press/release sets S, then async reset mid-count on Us
        set_raw(7'b1000010);
        repeat (20) step();
        set_raw(7'b0000010);
        repeat (20) step();
        check("S_after_press_release", {31'd0, S}, 32'd1);
        set_raw(7'b0010010);
        repeat (10) step();
        check("Us_pending", {31'd0, Us}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {23'd0, dut_all()}, 32'd0);
        model_reset();
        step();
        rst = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (e == 11) check("post_reset_edge11", {29'd0, ready, Us, S}, 32'd0);
            if (e == 12) check("post_reset_edge12", {29'd0, ready, Us, S}, 32'b110);
        end

        // All six sensors rising together
        set_raw(7'd0);
        repeat (20) step();
        set_raw(7'b0111111);
        found = 1'b0;
        for (int k = 1; k <= 40 && !found; k++) begin
            step();
            if (T | Us | Ua | L | M | H) found = 1'b1;
        end
        check("same_edge_rise", {25'd0, found, T, Us, Ua, L, M, H}, 32'h7f);

        // Random slowly changing inputs against the model
        for (int c = 0; c < 400; c++) begin
            v = cur_raw;
            for (int i = 0; i < 7; i++)
                if ($urandom_range(0, 5) == 0) v[i] = ~v[i];
            set_raw(v);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
